// File: rtl/shift_seq_16b.sv
// shift_seq_16b: multi-cycle 16-bit left shifter for shift instructions.
// Shifts the captured operand 2 bits per cycle through a chain of four
// 4-bit x2 slices, with a separate 1-bit step for an odd remainder.
// The overflow flag collects every bit pushed out of bit 15.

// One 4-bit slice of the x2 chain: the two low input bits move up,
// the two bits from the slice below (cin) enter at the bottom, and the
// top two bits leave through cout toward the next slice.
module left_shifter_x2_4b (
  input  logic [3:0] d,
  input  logic [1:0] cin,
  output logic [3:0] q,
  output logic [1:0] cout
);

  assign q    = {d[1:0], cin};
  assign cout = d[3:2];

endmodule

module shift_seq_16b (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] din,
  input  logic [3:0]  amt,
  input  logic        fill,
  output logic [15:0] dout,
  output logic        busy,
  output logic        done,
  output logic        ovf
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t      state, state_n;
  logic [3:0]  rem, rem_n;
  logic        fill_r, fill_n;
  logic [15:0] dout_n;
  logic        ovf_n;
  logic        busy_n;
  logic        done_n;

  // Carry chain between slices: carry[1:0] is the fill pair entering
  // slice 0, carry[9:8] is the pair leaving bit 15/14 out of slice 3.
  logic [9:0]  carry;
  logic [15:0] x2_res;
  logic [15:0] x1_res;

  assign carry[1:0] = {fill_r, fill_r};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slice
      left_shifter_x2_4b u_slice (
        .d    (dout[4*gi+3:4*gi]),
        .cin  (carry[2*gi+1:2*gi]),
        .q    (x2_res[4*gi+3:4*gi]),
        .cout (carry[2*gi+3:2*gi+2])
      );
    end
  endgenerate

  // Odd-remainder path: single-bit shift with one fill bit.
  assign x1_res = {dout[14:0], fill_r};

  // Next-state, datapath and handshake decisions.
  always_comb begin
    state_n = state;
    dout_n  = dout;
    rem_n   = rem;
    fill_n  = fill_r;
    ovf_n   = ovf;
    busy_n  = busy;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          dout_n  = din;
          rem_n   = amt;
          fill_n  = fill;
          ovf_n   = 1'b0;
          busy_n  = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (rem >= 4'd2) begin
          dout_n = x2_res;
          ovf_n  = ovf | (|carry[9:8]);
          rem_n  = rem - 4'd2;
        end else if (rem == 4'd1) begin
          dout_n = x1_res;
          ovf_n  = ovf | dout[15];
          rem_n  = '0;
        end else begin
          state_n = IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      dout   <= '0;
      rem    <= '0;
      fill_r <= 1'b0;
      ovf    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      dout   <= dout_n;
      rem    <= rem_n;
      fill_r <= fill_n;
      ovf    <= ovf_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

endmodule

// File: tb/tb_shift_seq_16b.sv
// Self-checking bench for shift_seq_16b: directed scenarios with literal
// expectations plus randomized traffic against a transaction-level model.
module tb_shift_seq_16b;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] din;
  logic [3:0]  amt;
  logic        fill;
  logic [15:0] dout;
  logic        busy;
  logic        done;
  logic        ovf;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  shift_seq_16b dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .din   (din),
    .amt   (amt),
    .fill  (fill),
    .dout  (dout),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Result of shifting d left by s with fill bits; upper 16 bits hold
  // everything pushed out of bit 15.
  function automatic logic [31:0] shl(input logic [15:0] d, input int s, input logic f);
    logic [31:0] x;
    logic [31:0] m;
    x = {16'h0, d} << s;
    m = (32'd1 << s) - 32'd1;
    if (f) x = x | m;
    return x;
  endfunction

  // Transaction-level model: latency 1+ceil(amt/2) edges after accept,
  // and after k shifting edges min(2k, amt) bits have been shifted.
  logic        m_busy = 0, m_done = 0, m_ovf = 0;
  logic [15:0] m_dout = '0;
  logic [15:0] t_din;
  int          t_amt, t_k, t_total;
  logic        t_fill;

  always @(posedge clk) begin
    logic [31:0] r;
    int s;
    if (rst) begin
      m_busy = 0; m_done = 0; m_ovf = 0; m_dout = '0;
    end else if (!m_busy) begin
      m_done = 0;
      if (start) begin
        t_din = din; t_amt = int'(amt); t_fill = fill;
        t_k = 0; t_total = 1 + (t_amt + 1) / 2;
        m_busy = 1; m_dout = din; m_ovf = 0;
      end
    end else begin
      t_k++;
      s = (2 * t_k < t_amt) ? 2 * t_k : t_amt;
      r = shl(t_din, s, t_fill);
      m_dout = r[15:0];
      m_ovf = |r[31:16];
      if (t_k == t_total) begin
        m_busy = 0;
        m_done = 1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("dout", dout, m_dout);
      check("ovf", ovf, m_ovf);
      if (busy && done) check("busy_and_done", 1, 0);
    end
  end

  // Launch an operation from IDLE and wait for done; optionally pulse a
  // competing start at edge count poke_at, which must be ignored.
  task automatic do_op(input logic [15:0] d, input logic [3:0] a, input logic f,
                       input logic [15:0] ed, input logic eo, input int el,
                       input int poke_at, input string nm);
    int n;
    bit seen;
    start = 1; din = d; amt = a; fill = f;
    @(posedge clk);
    #2;
    start = 0; din = 16'($urandom); amt = 4'($urandom); fill = 1'($urandom);
    n = 0; seen = 0;
    while (n < 40 && !seen) begin
      @(posedge clk);
      n++;
      #1;
      if (done) seen = 1;
      if (poke_at != 0 && n == poke_at) begin
        start = 1; din = 16'h1234; amt = 4'd2;
      end else begin
        start = 0;
      end
    end
    check({nm, "_latency"}, n, el);
    check({nm, "_dout"}, dout, ed);
    check({nm, "_ovf"}, ovf, eo);
  endtask

  initial begin
    int cnt;
    rst = 1; start = 1; din = 16'hFFFF; amt = 4'd3; fill = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", dout, 16'h0000);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    chk_en = 1;
    rst = 0; start = 0;
    @(posedge clk);
    #1;
    check("idle_busy", busy, 0);

    do_op(16'h0F0F, 4'd5, 1'b0, 16'hE1E0, 1'b1, 4, 0, "amt5");
    do_op(16'h0001, 4'd15, 1'b1, 16'hFFFF, 1'b0, 9, 0, "amt15");
    do_op(16'hA5A5, 4'd0, 1'b0, 16'hA5A5, 1'b0, 1, 0, "amt0");
    do_op(16'h8000, 4'd1, 1'b0, 16'h0000, 1'b1, 2, 0, "b2b_amt1");
    @(posedge clk);
    #2;
    do_op(16'h00FF, 4'd8, 1'b0, 16'hFF00, 1'b0, 5, 2, "ignore_start");
    @(posedge clk);
    #1;
    check("single_done", done, 0);

    // Reset during a 12-bit shift, sampled at E3.
    #1;
    start = 1; din = 16'h1357; amt = 4'd12; fill = 0;
    @(posedge clk);
    #2 start = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1;
    check("midrst_dout", dout, 16'h0000);
    check("midrst_busy", busy, 0);
    check("midrst_ovf", ovf, 0);
    rst = 0;
    cnt = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
    check("midrst_no_done", cnt, 0);
    do_op(16'h0003, 4'd4, 1'b1, 16'h003F, 1'b0, 3, 0, "after_rst");

    // Randomized traffic, including starts while busy and rare resets.
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #2;
      start = ($urandom_range(0, 2) == 0);
      din   = 16'($urandom);
      amt   = 4'($urandom);
      fill  = 1'($urandom);
      rst   = ($urandom_range(0, 299) == 0);
    end
    @(posedge clk);
    #2;
    rst = 0; start = 0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
